// File: rtl/npc_car_ctrl_if.sv
// Pixel/frame bus between the VGA side and the NPC car controller.
interface npc_car_ctrl_if;
  logic       frame_clk;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [3:0] player_speed;
  logic       hold;
  logic [9:0] npcX;
  logic [9:0] npcY;
  logic       DrawNPC;
  logic [6:0] npccounter;
  logic       npc_active;
  logic       npc_passed;

  modport master (
    output frame_clk, DrawX, DrawY, player_speed, hold,
    input  npcX, npcY, DrawNPC, npccounter, npc_active, npc_passed
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, player_speed, hold,
    output npcX, npcY, DrawNPC, npccounter, npc_active, npc_passed
  );
endinterface

// File: rtl/npc_car_ctrl.sv
// Opponent car controller: spawns in a pseudo-random lane, moves by relative speed each
// frame, retires past the bottom/top edge and flags pixels inside its sprite box.
module npc_car_ctrl #(
  parameter int          CAR_W      = 40,
  parameter int          CAR_H      = 64,
  parameter int          SCR_H      = 240,
  parameter int          LANE_BASE  = 100,
  parameter int          LANE_PITCH = 48,
  parameter int          NPC_SPEED  = 3,
  parameter int          SPAWN_GAP  = 30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic         Clk,
  input  logic         Reset,
  npc_car_ctrl_if.slave bus
);

  localparam int GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  typedef enum logic [2:0] {IDLE, SPAWN, DRIVE, EXIT_BOT, EXIT_TOP} state_t;

  state_t        state;
  logic [2:0]    sync_pipe;
  logic [15:0]   lfsr;
  logic [GW-1:0] gap_cnt;
  logic [10:0]   y_int;
  logic [9:0]    npc_x;
  logic          npc_active;
  logic          npc_passed;

  // rising edge of the second synchronizer flop, delayed copy in sync_pipe[2]
  logic frame_tick;
  assign frame_tick = sync_pipe[1] & ~sync_pipe[2];

  logic        step;
  assign step = frame_tick & ~bus.hold;

  logic [15:0] lfsr_next;
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  logic [1:0] lane;
  assign lane = (lfsr[1:0] == 2'd3) ? 2'd1 : lfsr[1:0];

  logic signed [5:0]  dy;
  logic signed [11:0] s;
  logic               exit_bot, exit_top;
  assign dy       = $signed({2'b00, bus.player_speed}) - $signed(6'(NPC_SPEED));
  assign s        = $signed({1'b0, y_int}) + $signed({{6{dy[5]}}, dy});
  assign exit_bot = s >= $signed(12'(SCR_H + CAR_H));
  assign exit_top = s[11];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      sync_pipe  <= '0;
      lfsr       <= LFSR_SEED;
      gap_cnt    <= '0;
      y_int      <= '0;
      npc_x      <= 10'(LANE_BASE);
      npc_active <= 1'b0;
      npc_passed <= 1'b0;
    end else begin
      sync_pipe  <= {sync_pipe[1:0], bus.frame_clk};
      lfsr       <= lfsr_next;
      npc_passed <= 1'b0;
      case (state)
        IDLE: if (step) begin
          if (gap_cnt == GW'(SPAWN_GAP - 1)) begin
            gap_cnt <= '0;
            state   <= SPAWN;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        SPAWN: begin
          npc_x      <= 10'(LANE_BASE + int'(lane) * LANE_PITCH);
          y_int      <= '0;
          npc_active <= 1'b1;
          state      <= DRIVE;
        end
        DRIVE: if (step) begin
          if (exit_bot) begin
            npc_active <= 1'b0;
            npc_passed <= 1'b1;
            state      <= EXIT_BOT;
          end else if (exit_top) begin
            npc_active <= 1'b0;
            state      <= EXIT_TOP;
          end else begin
            y_int <= s[10:0];
          end
        end
        EXIT_BOT, EXIT_TOP: state <= IDLE;
        default:            state <= IDLE;
      endcase
    end
  end

  // sprite box test in 11 bits so the lower bound cannot wrap near the top edge
  logic [10:0] px, py;
  logic        x_hit, y_hit, draw;
  assign px    = {1'b0, bus.DrawX};
  assign py    = {1'b0, bus.DrawY};
  assign x_hit = (px >= {1'b0, npc_x}) && (px < ({1'b0, npc_x} + 11'(CAR_W)));
  assign y_hit = (py < y_int) && ((py + 11'(CAR_H)) >= y_int);
  assign draw  = (state == DRIVE) && x_hit && y_hit;

  assign bus.DrawNPC    = draw;
  assign bus.npccounter = draw ? 7'(py + 11'(CAR_H) - y_int) : 7'd0;
  assign bus.npcX       = npc_x;
  assign bus.npcY       = 10'(y_int - 11'(CAR_H));
  assign bus.npc_active = npc_active;
  assign bus.npc_passed = npc_passed;

endmodule

// File: tb/tb_npc_car_ctrl.sv
// Directed bench for npc_car_ctrl with a per-cycle reference model and literal anchors.
module tb_npc_car_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  npc_car_ctrl_if bus();

  npc_car_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int passed_cnt = 0;
  int pk = 0;

  // model: phase 0 idle, 1 spawn, 2 drive, 3 exit bottom, 4 exit top
  int          m_phase, m_gap, m_y, m_x, m_s, m_lane;
  logic [15:0] m_lfsr;
  bit          h1, h2, h3, m_tick;
  int          e_draw, e_cnt, dxi, dyi;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_phase = 0; m_gap = 0; m_y = 0; m_x = 100; m_lfsr = 16'hACE1;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      m_tick = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = bus.frame_clk;
      case (m_phase)
        0: if (m_tick && !bus.hold) begin
          if (m_gap == 29) begin m_gap = 0; m_phase = 1; end
          else m_gap++;
        end
        1: begin
          m_lane = int'(m_lfsr[1:0]);
          if (m_lane == 3) m_lane = 1;
          m_x = 100 + 48 * m_lane;
          m_y = 0;
          m_phase = 2;
        end
        2: if (m_tick && !bus.hold) begin
          m_s = m_y + int'(bus.player_speed) - 3;
          if (m_s >= 304) m_phase = 3;
          else if (m_s < 0) m_phase = 4;
          else m_y = m_s;
        end
        default: m_phase = 0;
      endcase
      m_lfsr = lfsr_step(m_lfsr);
    end
    #1;
    if (!Reset) begin
      dxi = int'(bus.DrawX);
      dyi = int'(bus.DrawY);
      e_draw = (m_phase == 2 && dxi >= m_x && dxi < m_x + 40 && dyi < m_y && dyi + 64 >= m_y) ? 1 : 0;
      e_cnt  = e_draw ? dyi + 64 - m_y : 0;
      check("npc_active", int'(bus.npc_active), (m_phase == 2) ? 1 : 0);
      check("npc_passed", int'(bus.npc_passed), (m_phase == 3) ? 1 : 0);
      check("npcX", int'(bus.npcX), m_x);
      check("npcY", int'(bus.npcY), (m_y - 64) & 1023);
      check("DrawNPC", int'(bus.DrawNPC), e_draw);
      check("npccounter", int'(bus.npccounter), e_cnt);
      if (bus.npc_passed) passed_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge Clk);
      pk++;
      bus.DrawX = 10'(90 + (pk * 13) % 170);
      bus.DrawY = 10'((pk * 11) % 330);
    end
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      bus.frame_clk = 1'b1;
      step(4);
      bus.frame_clk = 1'b0;
      step(4);
    end
  endtask

  int x0;

  initial begin
    bus.frame_clk = 1'b0; bus.DrawX = '0; bus.DrawY = '0;
    bus.player_speed = 4'd8; bus.hold = 1'b0;

    check("lfsr_model_step", int'(lfsr_step(16'hACE1)), 16'hE270);

    repeat (6) begin @(negedge Clk); bus.frame_clk = ~bus.frame_clk; end
    #1;
    check("rst_npcX", int'(bus.npcX), 100);
    check("rst_active", int'(bus.npc_active), 0);
    check("rst_passed", int'(bus.npc_passed), 0);
    check("rst_draw", int'(bus.DrawNPC), 0);
    check("rst_counter", int'(bus.npccounter), 0);
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    Reset = 1'b0;

    frames(29);
    check("no_early_spawn", int'(bus.npc_active), 0);
    frames(1);
    check("spawn_active", int'(bus.npc_active), 1);
    x0 = int'(bus.npcX);
    check("lane_set", (x0 == 100 || x0 == 148 || x0 == 196) ? 1 : 0, 1);

    frames(8);
    check("y40_npcY", int'(bus.npcY), 1000);
    @(negedge Clk); bus.DrawX = 10'(m_x); bus.DrawY = 10'd10;
    #1;
    check("pix_in_draw", int'(bus.DrawNPC), 1);
    check("pix_in_counter", int'(bus.npccounter), 34);
    bus.DrawX = 10'(m_x + 40);
    #1;
    check("pix_right_edge", int'(bus.DrawNPC), 0);

    frames(52);
    check("y300_npcY", int'(bus.npcY), 236);
    check("no_pass_yet", passed_cnt, 0);
    frames(1);
    check("passed_pulse_cnt", passed_cnt, 1);
    check("after_bot_active", int'(bus.npc_active), 0);

    frames(30);
    check("respawn_active", int'(bus.npc_active), 1);
    bus.player_speed = 4'd0;
    frames(1);
    check("exit_top_active", int'(bus.npc_active), 0);
    check("exit_top_no_pulse", passed_cnt, 1);

    bus.player_speed = 4'd8;
    frames(29);
    check("gap_restart_idle", int'(bus.npc_active), 0);
    frames(1);
    check("gap_restart_spawn", int'(bus.npc_active), 1);

    frames(2);
    check("y10_npcY", int'(bus.npcY), 970);
    bus.hold = 1'b1;
    frames(10);
    check("hold_npcY", int'(bus.npcY), 970);
    bus.hold = 1'b0;

    @(negedge Clk); bus.DrawX = 10'(m_x + 39); bus.DrawY = 10'd5;
    #1;
    check("pre_rst_draw", int'(bus.DrawNPC), 1);
    check("pre_rst_counter", int'(bus.npccounter), 59);
    #1 Reset = 1'b1;
    #1;
    check("async_rst_draw", int'(bus.DrawNPC), 0);
    check("async_rst_active", int'(bus.npc_active), 0);
    check("async_rst_npcX", int'(bus.npcX), 100);
    @(negedge Clk);
    Reset = 1'b0;

    frames(29);
    check("post_rst_idle", int'(bus.npc_active), 0);
    frames(1);
    check("post_rst_spawn", int'(bus.npc_active), 1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
